i2c_master_ctrl: RTL and testbench
==================================

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16: width of the prescale input.
REQ-002 SHALL have port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port prescale, input, PRESCALE_W: quarter-bit period is prescale+1 clk cycles; sampled only when leaving IDLE.
REQ-005 SHALL have port cmd_valid, input, 1, and port cmd_ready, output, 1: valid/ready command handshake.
REQ-006 SHALL have ports cmd_start, cmd_read, cmd_stop, cmd_nack, input, 1 each: issue (repeated) START; read byte (else write); issue STOP after byte; send NACK after a read (else ACK).
REQ-007 SHALL have port cmd_data, input, 8: write byte, MSB first.
REQ-008 SHALL have ports rsp_valid, output, 1; rsp_data, output, 8; rsp_nack, output, 1: one-cycle response pulse per command with read byte / slave NACK on write.
REQ-009 SHALL have port busy, output, 1: high when not in IDLE or while the bus is held between commands.
REQ-010 SHALL have ports scl_i and sda_i, input, 1 each, and ports scl_o, scl_t, sda_o, sda_t, output, 1 each: pin pads; _t=1 releases the line, _t=0 drives it low; _o SHALL be 0 whenever _t=0.

Function
REQ-011 SHALL use FSM states IDLE, START, ADDR_BIT, ACK, STOP, HOLD.
REQ-012 SHALL assert cmd_ready only in IDLE and HOLD; a command SHALL be accepted on the cycle cmd_valid&&cmd_ready, and fields SHALL be latched then.
REQ-013 From IDLE, a command SHALL go to START only if cmd_start=1; otherwise it SHALL be consumed with rsp_valid=1 and rsp_nack=1 and no bus activity.
REQ-014 START SHALL run 4 quarter phases: release SDA; release SCL; drive SDA low; drive SCL low. From IDLE the first two phases are already satisfied but SHALL still be timed.
REQ-015 ADDR_BIT SHALL transfer 8 bits, each 4 quarter phases: SCL low with SDA set up; SCL released; SCL high, with sda_i sampled at the end of this phase on reads; SCL low.
REQ-016 On reads, SDA SHALL be released during data bits. In ACK, SDA SHALL be released on writes, with sda_i sampled into rsp_nack, and driven per cmd_nack on reads.
REQ-017 Clock stretching: in any phase where SCL is released, the quarter counter SHALL hold at 0 until scl_i=1.
REQ-018 After ACK, the block SHALL go to STOP if cmd_stop=1, else to HOLD, with SCL low and SDA released.
REQ-019 STOP SHALL run 4 phases: drive SDA low; release SCL; release SDA; idle quarter; then go to IDLE.
REQ-020 rsp_valid SHALL pulse exactly once, for 1 cycle, on exit from ACK. rsp_data SHALL hold the shifted byte on reads and cmd_data on writes.
REQ-021 In HOLD, an accepted command with cmd_start=1 SHALL produce a repeated START; with cmd_start=0 it SHALL go directly to ADDR_BIT.
REQ-022 The bit counter SHALL be 3 bits wide and SHALL end at bit 0 without wrap-around. The quarter counter SHALL be PRESCALE_W bits wide; prescale=0 SHALL give 1-cycle quarters.
REQ-023 Simultaneous cmd_valid and state exit SHALL NOT accept a command until cmd_ready is visible on the next cycle.

Reset
REQ-024 While rst_n=0, outputs SHALL be: state IDLE, scl_t=1, sda_t=1, scl_o=1, sda_o=1, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_nack=0, busy=0, all counters 0.
REQ-025 Reset asserted mid-transfer SHALL release both lines within the same cycle (asynchronous) without generating STOP. cmd_ready SHALL rise on the first clk edge after rst_n=1.

Verification
REQ-026 Write case: prescale=3, cmd {start,write,stop}, data=0xA5, slave ACKs -> START, bits 1,0,1,0,0,1,0,1, rsp_valid with rsp_nack=0, STOP; transfer lasts (4+32+4+4)*4 clk plus handshake.
REQ-027 Read case: cmd {start,read,nack,stop}, slave drives 0x3C -> rsp_data=0x3C, SDA released at the ACK bit, then STOP.
REQ-028 Write to absent slave (sda_i stays 1 at ACK) -> rsp_nack=1, STOP still issued, busy falls.
REQ-029 Repeated start: write without stop, then {start,read,stop} -> no STOP between, SDA falls while SCL high, busy stays high throughout.
REQ-030 Stretch case: slave holds scl_i=0 for 50 clk in bit 3 -> phase timing frozen, data correct. Reset pulsed during bit 5 -> scl_t=sda_t=1 immediately, and the next command completes normally.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// I2C byte-level master: one command moves one byte with optional START/STOP.
// Ports: clk, rst_n, prescale, cmd_* (valid/ready command), rsp_* (result), busy, SCL/SDA pads.
module i2c_master_ctrl #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_start,
    input  logic                  cmd_read,
    input  logic                  cmd_stop,
    input  logic                  cmd_nack,
    input  logic [7:0]            cmd_data,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_data,
    output logic                  rsp_nack,
    output logic                  busy,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_o,
    output logic                  scl_t,
    output logic                  sda_o,
    output logic                  sda_t
);

    typedef enum logic [2:0] {
        IDLE, START, ADDR_BIT, ACK, STOP, HOLD
    } state_t;

    state_t state, state_nx;

    logic [PRESCALE_W-1:0] qcnt, presc_r;
    logic [1:0] phase;
    logic [2:0] bitcnt;
    logic [7:0] shreg, data_r;
    logic rd_r, stop_r, nack_r, rep_r, samp_r;
    logic scl_rel, sda_rel;
    logic accept, stall, tick, last_q;

    assign accept = cmd_valid && cmd_ready;
    // A released SCL that is still low is a slave stretching the clock.
    assign stall  = scl_rel && !scl_i;
    assign tick   = (qcnt == presc_r) && !stall;
    assign last_q = tick && (phase == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_nx;
            cmd_ready <= (state_nx == IDLE) || (state_nx == HOLD);
        end
    end

    always_comb begin
        state_nx = state;
        scl_rel  = 1'b1;
        sda_rel  = 1'b1;
        unique case (state)
            IDLE: begin
                if (accept && cmd_start) state_nx = START;
            end
            START: begin
                // Repeated START begins with SCL still low from HOLD.
                scl_rel = (phase == 2'd0) ? !rep_r : (phase != 2'd3);
                sda_rel = (phase < 2'd2);
                if (last_q) state_nx = ADDR_BIT;
            end
            ADDR_BIT: begin
                scl_rel = (phase == 2'd1) || (phase == 2'd2);
                sda_rel = rd_r || shreg[7];
                if (last_q && bitcnt == 3'd0) state_nx = ACK;
            end
            ACK: begin
                scl_rel = (phase == 2'd1) || (phase == 2'd2);
                sda_rel = rd_r ? nack_r : 1'b1;
                if (last_q) state_nx = stop_r ? STOP : HOLD;
            end
            STOP: begin
                scl_rel = (phase != 2'd0);
                sda_rel = (phase >= 2'd2);
                if (last_q) state_nx = IDLE;
            end
            HOLD: begin
                scl_rel = 1'b0;
                if (accept) state_nx = cmd_start ? START : ADDR_BIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt      <= '0;
            presc_r   <= '0;
            phase     <= 2'd0;
            bitcnt    <= 3'd0;
            shreg     <= 8'd0;
            data_r    <= 8'd0;
            rd_r      <= 1'b0;
            stop_r    <= 1'b0;
            nack_r    <= 1'b0;
            rep_r     <= 1'b0;
            samp_r    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
            rsp_nack  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                rd_r   <= cmd_read;
                stop_r <= cmd_stop;
                nack_r <= cmd_nack;
                data_r <= cmd_data;
                shreg  <= cmd_data;
                qcnt   <= '0;
                phase  <= 2'd0;
                bitcnt <= 3'd7;
                rep_r  <= (state == HOLD);
                if (state == IDLE && cmd_start) presc_r <= prescale;
                // No START from IDLE: nothing to address, reject at once.
                if (state == IDLE && !cmd_start) begin
                    rsp_valid <= 1'b1;
                    rsp_nack  <= 1'b1;
                end
            end else if (state != IDLE && state != HOLD) begin
                if (!tick) begin
                    qcnt <= stall ? '0 : qcnt + 1'b1;
                end else begin
                    qcnt  <= '0;
                    phase <= phase + 2'd1;
                    if (state == ADDR_BIT && phase == 2'd2 && rd_r)
                        shreg <= {shreg[6:0], sda_i};
                    if (state == ADDR_BIT && phase == 2'd3) begin
                        if (!rd_r) shreg <= {shreg[6:0], 1'b0};
                        if (bitcnt != 3'd0) bitcnt <= bitcnt - 3'd1;
                    end
                    if (state == ACK && phase == 2'd2)
                        samp_r <= sda_i;
                    if (state == ACK && phase == 2'd3) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= rd_r ? shreg : data_r;
                        rsp_nack  <= !rd_r && samp_r;
                    end
                end
            end
        end
    end

    // Open-drain pads: _o mirrors _t so it is low whenever the line is driven.
    assign scl_t = scl_rel;
    assign sda_t = sda_rel;
    assign scl_o = scl_rel;
    assign sda_o = sda_rel;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural open-drain slave.
// Slave decodes START/STOP/bits from the bus and answers ACK or read data.
module tb_i2c_master_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] prescale = 16'd3;
    logic cmd_valid = 1'b0, cmd_ready;
    logic cmd_start = 1'b0, cmd_read = 1'b0;
    logic cmd_stop = 1'b0, cmd_nack = 1'b0;
    logic [7:0] cmd_data = 8'd0;
    logic rsp_valid, rsp_nack, busy;
    logic [7:0] rsp_data;
    logic scl_i, sda_i, scl_o, scl_t, sda_o, sda_t;

    always #5 clk = ~clk;

    i2c_master_ctrl #(.PRESCALE_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .prescale(prescale),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_read(cmd_read),
        .cmd_stop(cmd_stop), .cmd_nack(cmd_nack),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_nack(rsp_nack), .busy(busy),
        .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o),
        .scl_t(scl_t), .sda_o(sda_o), .sda_t(sda_t)
    );

    // Slave model state
    logic slv_sda = 1'b1;
    int st_cnt = 0;
    int bitn = 0;
    int starts = 0, stops = 0;
    logic [7:0] rx = 8'd0, rx_byte = 8'd0, slv_byte = 8'd0;
    logic m_ack = 1'b1;
    logic slv_rd = 1'b0, slv_ack = 1'b1, armed = 1'b0;
    logic stretch_en = 1'b0;
    logic p_scl = 1'b1, p_sda = 1'b1, c_scl, c_sda;

    // Monitor state
    int nrsp = 0, rsp0 = 0, busy_cyc = 0;
    logic [7:0] last_data = 8'd0;
    logic last_nack = 1'b0;
    logic watch = 1'b0, busy_drop = 1'b0;

    int n_cmp = 0, n_bad = 0;

    assign scl_i = scl_t & (st_cnt == 0);
    assign sda_i = sda_t & slv_sda;

    always @(negedge clk) begin
        if (stretch_en && scl_t && !p_scl && bitn == 3) begin
            st_cnt = 50;
            stretch_en = 1'b0;
        end else if (st_cnt > 0) begin
            st_cnt--;
        end
        c_scl = scl_t && (st_cnt == 0);
        c_sda = sda_t && slv_sda;
        if (p_scl && c_scl && p_sda && !c_sda) begin
            starts++;
            bitn = 0;
            armed = 1'b1;
            slv_sda = 1'b1;
        end else if (p_scl && c_scl && !p_sda && c_sda) begin
            stops++;
            bitn = 0;
        end else if (!p_scl && c_scl) begin
            if (bitn < 8) begin
                rx = {rx[6:0], c_sda};
                bitn++;
            end else if (bitn == 8) begin
                rx_byte = rx;
                m_ack = c_sda;
                bitn = 9;
            end
        end else if (p_scl && !c_scl) begin
            if (bitn == 9) begin
                bitn = 0;
                armed = 1'b0;
            end
            if (bitn < 8)
                slv_sda = (slv_rd && armed) ? slv_byte[7-bitn] : 1'b1;
            else
                slv_sda = !(slv_ack && !slv_rd);
        end
        p_scl = c_scl;
        p_sda = c_sda;
        if (rsp_valid) begin
            nrsp++;
            last_data = rsp_data;
            last_nack = rsp_nack;
        end
        if (busy) busy_cyc++;
        else if (watch) busy_drop = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic s, input logic r, input logic p,
                         input logic k, input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk); #1;
        cmd_start = s; cmd_read = r; cmd_stop = p;
        cmd_nack = k; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && t < 2000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("cmd_rdy", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run(input logic s, input logic r, input logic p,
                       input logic k, input logic [7:0] d);
        int t;
        t = 0;
        rsp0 = nrsp;
        busy_cyc = 0;
        issue(s, r, p, k, d);
        while (nrsp == rsp0 && t < 5000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("rsp_cnt", nrsp - rsp0, 32'd1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 2000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, p0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_scl_t", 32'(scl_t), 32'd1);
        chk("rst_sda_t", 32'(sda_t), 32'd1);
        chk("rst_scl_o", 32'(scl_o), 32'd1);
        chk("rst_sda_o", 32'(sda_o), 32'd1);
        chk("rst_rdy", 32'(cmd_ready), 32'd0);
        chk("rst_rspv", 32'(rsp_valid), 32'd0);
        chk("rst_rspd", 32'(rsp_data), 32'd0);
        chk("rst_rspn", 32'(rsp_nack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rdy_pre", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("rdy_post", 32'(cmd_ready), 32'd1);

        // Write 0xA5 with ACK, prescale 3
        slv_rd = 1'b0; slv_ack = 1'b1;
        s0 = starts; p0 = stops;
        run(1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
        wait_idle();
        chk("wr_byte", 32'(rx_byte), 32'hA5);
        chk("wr_nack", 32'(last_nack), 32'd0);
        chk("wr_data", 32'(last_data), 32'hA5);
        chk("wr_pulse", nrsp - rsp0, 32'd1);
        chk("wr_start", starts - s0, 32'd1);
        chk("wr_stop", stops - p0, 32'd1);
        chk("wr_cyc", busy_cyc, 32'd176);

        // Read 0x3C, master NACKs
        slv_rd = 1'b1; slv_byte = 8'h3C;
        p0 = stops;
        run(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        wait_idle();
        chk("rd_data", 32'(last_data), 32'h3C);
        chk("rd_nack", 32'(last_nack), 32'd0);
        chk("rd_mack", 32'(m_ack), 32'd1);
        chk("rd_stop", stops - p0, 32'd1);

        // Absent slave
        slv_rd = 1'b0; slv_ack = 1'b0;
        p0 = stops;
        run(1'b1, 1'b0, 1'b1, 1'b0, 8'h3F);
        wait_idle();
        chk("ns_nack", 32'(last_nack), 32'd1);
        chk("ns_stop", stops - p0, 32'd1);
        chk("ns_busy", 32'(busy), 32'd0);

        // Command without START from IDLE is rejected
        s0 = starts;
        run(1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
        chk("nos_nack", 32'(last_nack), 32'd1);
        chk("nos_busy", 32'(busy), 32'd0);
        chk("nos_start", starts - s0, 32'd0);

        // Write, write-from-HOLD, repeated START read
        slv_ack = 1'b1;
        s0 = starts; p0 = stops;
        run(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
        busy_drop = 1'b0;
        watch = 1'b1;
        chk("h_byte", 32'(rx_byte), 32'h5A);
        chk("h_busy", 32'(busy), 32'd1);
        chk("h_scl", 32'(scl_t), 32'd0);
        chk("h_sda", 32'(sda_t), 32'd1);
        run(1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        chk("h2_byte", 32'(rx_byte), 32'h11);
        chk("h2_nack", 32'(last_nack), 32'd0);
        slv_rd = 1'b1; slv_byte = 8'h96;
        run(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("rs_drop", 32'(busy_drop), 32'd0);
        watch = 1'b0;
        wait_idle();
        chk("rs_data", 32'(last_data), 32'h96);
        chk("rs_mack", 32'(m_ack), 32'd0);
        chk("rs_start", starts - s0, 32'd2);
        chk("rs_stop", stops - p0, 32'd1);

        // Clock stretch of 50 clk in bit 3
        slv_rd = 1'b0;
        stretch_en = 1'b1;
        run(1'b1, 1'b0, 1'b1, 1'b0, 8'hC3);
        wait_idle();
        chk("st_byte", 32'(rx_byte), 32'hC3);
        chk("st_cyc", busy_cyc, 32'd226);

        // Minimum prescale: 1-cycle quarters
        prescale = 16'd0;
        run(1'b1, 1'b0, 1'b1, 1'b0, 8'h69);
        wait_idle();
        chk("p0_byte", 32'(rx_byte), 32'h69);
        chk("p0_nack", 32'(last_nack), 32'd0);
        chk("p0_cyc", busy_cyc, 32'd44);

        // Reset in the middle of a byte
        prescale = 16'd3;
        p0 = stops;
        rsp0 = nrsp;
        issue(1'b1, 1'b0, 1'b1, 1'b0, 8'hF0);
        begin
            int t;
            t = 0;
            while (!(bitn == 5 && !scl_t) && t < 2000) begin
                @(negedge clk); #1;
                t++;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        chk("ar_scl", 32'(scl_t), 32'd1);
        chk("ar_sda", 32'(sda_t), 32'd1);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_rdy", 32'(cmd_ready), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ar_rdy2", 32'(cmd_ready), 32'd1);
        chk("ar_stop", stops - p0, 32'd0);
        chk("ar_rsp", nrsp - rsp0, 32'd0);
        p0 = stops;
        run(1'b1, 1'b0, 1'b1, 1'b0, 8'h81);
        wait_idle();
        chk("ar_byte", 32'(rx_byte), 32'h81);
        chk("ar_nack", 32'(last_nack), 32'd0);
        chk("ar_stop2", stops - p0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
